// File: rtl/receivers_arbiter_fifo_if.sv
// receivers_arbiter_fifo_if
// Valid/ready record stream from the receiver arbiter FIFO to the serial
// transmitter. The producer side (master) owns the head record and its
// valid flag. The consumer side (slave) answers with out_ready.
//   out_valid      : FIFO head holds a record
//   out_ready      : consumer takes the head this cycle
//   out_channel    : channel tag of the head record
//   out_data       : decoded data of the head record
//   out_timestamp  : capture timestamp of the head record
interface receivers_arbiter_fifo_if #(
  parameter int DATA_WIDTH = 17,
  parameter int TS_WIDTH   = 24,
  parameter int CH_WIDTH   = 4
);
  logic                  out_valid;
  logic                  out_ready;
  logic [CH_WIDTH-1:0]   out_channel;
  logic [DATA_WIDTH-1:0] out_data;
  logic [TS_WIDTH-1:0]   out_timestamp;

  modport master (
    output out_valid, out_channel, out_data, out_timestamp,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_channel, out_data, out_timestamp,
    output out_ready
  );
endinterface

// File: rtl/receivers_arbiter_fifo.sv
// receivers_arbiter_fifo
// Owns the free-running system timestamp. Serves NUM_CHANNELS receiver
// managers with round-robin arbitration. Each capture is acknowledged with a
// one-cycle reset_decoder pulse. Captured records {channel, data, timestamp}
// are queued in a first-word-fall-through FIFO, and the serial transmitter
// drains that FIFO.
// Ports:
//   clk_96MHz            : sole clock, rising edge
//   reset                : synchronous, active-high
//   system_timestamp     : free-running counter sent to the receiver managers
//   data_availible       : per-channel "frame decoded" level
//   decoded_data         : channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   timestamp_last_data  : channel i at [i*TS_WIDTH +: TS_WIDTH]
//   reset_decoder        : one-cycle capture acknowledge per channel
//   fifo_level           : current FIFO occupancy
//   out_if               : head-record valid/ready stream (master side)
//   stall_count          : only when RECV_STALL_COUNT_EN is defined; counts
//                          cycles with a pending request blocked by a full FIFO
// Optional feature macro: RECV_STALL_COUNT_EN
module receivers_arbiter_fifo #(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 17,
  parameter int TS_WIDTH     = 24,
  parameter int FIFO_DEPTH   = 8,
  parameter int CH_WIDTH     = 4
) (
  input  logic                             clk_96MHz,
  input  logic                             reset,
  output logic [TS_WIDTH-1:0]              system_timestamp,
  input  logic [NUM_CHANNELS-1:0]          data_availible,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] decoded_data,
  input  logic [NUM_CHANNELS*TS_WIDTH-1:0] timestamp_last_data,
  output logic [NUM_CHANNELS-1:0]          reset_decoder,
`ifdef RECV_STALL_COUNT_EN
  output logic [15:0]                      stall_count,
`endif
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
  receivers_arbiter_fifo_if.master         out_if
);

  localparam int ADDR_WIDTH  = $clog2(FIFO_DEPTH);
  localparam int LEVEL_WIDTH = ADDR_WIDTH + 1;
  localparam int REC_WIDTH   = CH_WIDTH + DATA_WIDTH + TS_WIDTH;

  logic [NUM_CHANNELS-1:0] pending;
  logic [NUM_CHANNELS-1:0] req;
  logic [NUM_CHANNELS-1:0] grant_onehot;
  logic [CH_WIDTH-1:0]     rr_ptr;
  logic [CH_WIDTH-1:0]     grant_idx;
  logic                    hi_found;
  logic                    lo_found;
  logic [CH_WIDTH-1:0]     hi_idx;
  logic [CH_WIDTH-1:0]     lo_idx;
  logic                    fifo_full;
  logic                    push;
  logic                    pop;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [TS_WIDTH-1:0]     sel_ts;

  logic [REC_WIDTH-1:0]    mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [ADDR_WIDTH-1:0]   rd_ptr;
  logic [REC_WIDTH-1:0]    head;
  logic                    head_valid;

  // A channel stays masked after its capture until its decoder has dropped
  // data_availible. This stops the same frame from being captured twice.
  assign req = data_availible & ~pending;

  // Full is taken from the registered level. A pop in the same cycle does
  // not open a slot for a push.
  assign fifo_full = (fifo_level == LEVEL_WIDTH'(FIFO_DEPTH));

  assign head_valid = (fifo_level != '0);
  assign pop        = head_valid & out_if.out_ready;

  // The round-robin scan is split into two priority searches. The first
  // looks for a request at or above rr_ptr. If none is found, the second
  // wraps around and takes the lowest request.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (!hi_found && req[i] && (CH_WIDTH'(i) >= rr_ptr)) begin
        hi_found = 1'b1;
        hi_idx   = CH_WIDTH'(i);
      end
    end
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (!lo_found && req[i]) begin
        lo_found = 1'b1;
        lo_idx   = CH_WIDTH'(i);
      end
    end
  end

  // Pick the winner and mux its data and timestamp into the write record.
  always_comb begin
    grant_idx    = hi_found ? hi_idx : lo_idx;
    push         = (hi_found | lo_found) & ~fifo_full;
    grant_onehot = '0;
    sel_data     = '0;
    sel_ts       = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      grant_onehot[i] = push && (grant_idx == CH_WIDTH'(i));
      if (grant_onehot[i]) begin
        sel_data = decoded_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_ts   = timestamp_last_data[i*TS_WIDTH +: TS_WIDTH];
      end
    end
  end

  // Free-running timestamp. It wraps naturally at 2^TS_WIDTH.
  always_ff @(posedge clk_96MHz) begin
    if (reset) system_timestamp <= '0;
    else       system_timestamp <= system_timestamp + TS_WIDTH'(1);
  end

  // Arbiter state. rr_ptr moves one past the last winner. The acknowledge
  // pulse is the registered grant vector. A pending bit clears as soon as
  // its data_availible is sampled low.
  always_ff @(posedge clk_96MHz) begin
    if (reset) begin
      rr_ptr        <= '0;
      pending       <= '0;
      reset_decoder <= '0;
    end else begin
      reset_decoder <= grant_onehot;
      pending       <= (pending | grant_onehot) & data_availible;
      if (push) begin
        if (grant_idx == CH_WIDTH'(NUM_CHANNELS - 1)) rr_ptr <= '0;
        else                                          rr_ptr <= grant_idx + CH_WIDTH'(1);
      end
    end
  end

  // FIFO storage. This block has no reset because the pointers and level
  // decide what is valid.
  always_ff @(posedge clk_96MHz) begin
    if (push && !reset) mem[wr_ptr] <= {grant_idx, sel_data, sel_ts};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_96MHz) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LEVEL_WIDTH'(1);
        2'b01:   fifo_level <= fifo_level - LEVEL_WIDTH'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // The head fields are forced to zero while the FIFO is empty. As a result
  // the outputs read 0 after reset even though memory is uninitialised.
  assign head                 = mem[rd_ptr];
  assign out_if.out_valid     = head_valid;
  assign out_if.out_channel   = head_valid ? head[REC_WIDTH-1 -: CH_WIDTH] : '0;
  assign out_if.out_data      = head_valid ? head[TS_WIDTH +: DATA_WIDTH] : '0;
  assign out_if.out_timestamp = head_valid ? head[TS_WIDTH-1:0] : '0;

`ifdef RECV_STALL_COUNT_EN
  // Counts cycles where a request is blocked only because the FIFO is full.
  // The count saturates at 16'hFFFF.
  always_ff @(posedge clk_96MHz) begin
    if (reset)                                          stall_count <= '0;
    else if ((|req) && fifo_full && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_receivers_arbiter_fifo.sv
// tb_receivers_arbiter_fifo
// Directed bench for receivers_arbiter_fifo with the default parameters
// (4 channels, 17-bit data, 24-bit timestamps, 8-entry FIFO). A cycle table
// covers single captures, a held request and round-robin ordering. Hand
// sequences cover FIFO full/stall, the drain order and reset mid-operation.
// Define RECV_STALL_COUNT_EN to also check the stall counter.
module tb_receivers_arbiter_fifo;

  logic        clk_96MHz = 1'b0;
  logic        reset;
  logic [23:0] system_timestamp;
  logic [3:0]  data_availible;
  logic [67:0] decoded_data;
  logic [95:0] timestamp_last_data;
  logic [3:0]  reset_decoder;
  logic [3:0]  fifo_level;
`ifdef RECV_STALL_COUNT_EN
  logic [15:0] stall_count;
`endif

  int compared   = 0;
  int mismatched = 0;
  int pulses;

  logic [16:0] ch_data [4] = '{17'h00A5A, 17'h15555, 17'h1ABCD, 17'h0F0F0};
  logic [23:0] ch_ts   [4] = '{24'h000010, 24'h0ABCDE, 24'h000123, 24'hFFFFFE};
  logic [3:0]  drain_order [8] = '{4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1};

  receivers_arbiter_fifo_if #(.DATA_WIDTH(17), .TS_WIDTH(24), .CH_WIDTH(4)) out_if ();

  receivers_arbiter_fifo #(
    .NUM_CHANNELS(4), .DATA_WIDTH(17), .TS_WIDTH(24), .FIFO_DEPTH(8), .CH_WIDTH(4)
  ) dut (
    .clk_96MHz           (clk_96MHz),
    .reset               (reset),
    .system_timestamp    (system_timestamp),
    .data_availible      (data_availible),
    .decoded_data        (decoded_data),
    .timestamp_last_data (timestamp_last_data),
    .reset_decoder       (reset_decoder),
`ifdef RECV_STALL_COUNT_EN
    .stall_count         (stall_count),
`endif
    .fifo_level          (fifo_level),
    .out_if              (out_if.master)
  );

  always #5 clk_96MHz = ~clk_96MHz;

  typedef struct {
    logic [3:0] da;
    logic       ready;
    logic [3:0] exp_rd;
    logic       exp_valid;
    logic [3:0] exp_ch;
    logic [3:0] exp_level;
  } vec_t;

  vec_t vecs [25];

  // Drive one cycle of inputs, then sample 1 ns after the rising edge.
  task automatic applyStimulus(input logic [3:0] da, input logic ready);
    data_availible   = da;
    out_if.out_ready = ready;
    @(posedge clk_96MHz);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Compares the head record against the constants for channel ch.
  task automatic checkHead(input string name, input logic valid, input logic [3:0] ch);
    checkOutput({name, "_valid"}, 64'(out_if.out_valid), 64'(valid));
    checkOutput({name, "_ch"}, 64'(out_if.out_channel), valid ? 64'(ch) : 64'd0);
    checkOutput({name, "_data"}, 64'(out_if.out_data), valid ? 64'(ch_data[ch]) : 64'd0);
    checkOutput({name, "_ts"}, 64'(out_if.out_timestamp), valid ? 64'(ch_ts[ch]) : 64'd0);
  endtask

  initial begin
    // Each row is {da, ready, exp_rd, exp_valid, exp_ch, exp_level}.
    // Single capture of channel 2.
    vecs[0]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 4'd2, 4'd1};
    vecs[1]  = '{4'b0100, 1'b0, 4'b0000, 1'b1, 4'd2, 4'd1};
    vecs[2]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'd0, 4'd0};
    // Channel 1 holds its request for 10 cycles after the ack.
    vecs[3]  = '{4'b0010, 1'b0, 4'b0010, 1'b1, 4'd1, 4'd1};
    for (int i = 4; i < 14; i++) vecs[i] = '{4'b0010, 1'b0, 4'b0000, 1'b1, 4'd1, 4'd1};
    vecs[14] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'd0, 4'd0};
    // Capture channel 3 so that rr_ptr wraps back to 0.
    vecs[15] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 4'd3, 4'd1};
    vecs[16] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'd0, 4'd0};
    // Channels 0, 1 and 3 request together. Each drops 2 cycles after its ack.
    vecs[17] = '{4'b1011, 1'b1, 4'b0001, 1'b1, 4'd0, 4'd1};
    vecs[18] = '{4'b1011, 1'b1, 4'b0010, 1'b1, 4'd1, 4'd1};
    vecs[19] = '{4'b1011, 1'b1, 4'b1000, 1'b1, 4'd3, 4'd1};
    vecs[20] = '{4'b1010, 1'b1, 4'b0000, 1'b0, 4'd0, 4'd0};
    vecs[21] = '{4'b1000, 1'b1, 4'b0000, 1'b0, 4'd0, 4'd0};
    vecs[22] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'd0, 4'd0};
    // rr_ptr is back at 0, so channel 0 wins when all channels request.
    vecs[23] = '{4'b1111, 1'b0, 4'b0001, 1'b1, 4'd0, 4'd1};
    vecs[24] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'd0, 4'd0};

    decoded_data        = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};
    timestamp_last_data = {ch_ts[3], ch_ts[2], ch_ts[1], ch_ts[0]};
    reset               = 1'b1;
    applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b0000, 1'b0);

    // Reset state.
    checkOutput("rst_ts", 64'(system_timestamp), 64'd0);
    checkOutput("rst_rd", 64'(reset_decoder), 64'd0);
    checkOutput("rst_level", 64'(fifo_level), 64'd0);
    checkHead("rst_head", 1'b0, 4'd0);
`ifdef RECV_STALL_COUNT_EN
    checkOutput("rst_stall", 64'(stall_count), 64'd0);
`endif

    // Five idle cycles after reset release.
    reset = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(4'b0000, 1'b0);
    checkOutput("idle_ts", 64'(system_timestamp), 64'd5);
    checkOutput("idle_valid", 64'(out_if.out_valid), 64'd0);
    checkOutput("idle_rd", 64'(reset_decoder), 64'd0);

    // Table-driven cycles.
    for (int i = 0; i < 25; i++) begin
      applyStimulus(vecs[i].da, vecs[i].ready);
      checkOutput($sformatf("vec%0d_rd", i), 64'(reset_decoder), 64'(vecs[i].exp_rd));
      checkOutput($sformatf("vec%0d_level", i), 64'(fifo_level), 64'(vecs[i].exp_level));
      checkHead($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_ch);
    end

    // Fill with out_ready low. Requests alternate with idle cycles so pending
    // clears. rr_ptr starts at 1, so the grant order is 1,2,3,0,1,2,3,0.
    // The last two request cycles stall on a full FIFO.
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(4'b1111, 1'b0);
      pulses += $countones(reset_decoder);
      applyStimulus(4'b0000, 1'b0);
      pulses += $countones(reset_decoder);
    end
    checkOutput("fill_pulses", 64'(pulses), 64'd8);
    checkOutput("fill_level", 64'(fifo_level), 64'd8);
    checkHead("fill_head", 1'b1, 4'd1);
`ifdef RECV_STALL_COUNT_EN
    checkOutput("fill_stall", 64'(stall_count), 64'd2);
`endif

    // Hold every request for 7 cycles while full. No acks are expected.
    for (int k = 0; k < 7; k++) begin
      applyStimulus(4'b1111, 1'b0);
      pulses += $countones(reset_decoder);
    end
    checkOutput("full_no_ack", 64'(pulses), 64'd8);
    checkOutput("full_level", 64'(fifo_level), 64'd8);
`ifdef RECV_STALL_COUNT_EN
    checkOutput("full_stall", 64'(stall_count), 64'd9);
`endif

    // One pop. The registered level is still full, so there is no grant yet.
    applyStimulus(4'b1111, 1'b1);
    checkOutput("pop_level", 64'(fifo_level), 64'd7);
    checkOutput("pop_rd", 64'(reset_decoder), 64'd0);
    checkHead("pop_head", 1'b1, 4'd2);

    // The freed slot is granted the next cycle, to channel 1 (rr_ptr = 1).
    applyStimulus(4'b1111, 1'b0);
    checkOutput("refill_rd", 64'(reset_decoder), 64'b0010);
    checkOutput("refill_level", 64'(fifo_level), 64'd8);
    checkHead("refill_head", 1'b1, 4'd2);

    // Drain and check the order and contents of every record.
    for (int k = 0; k < 8; k++) begin
      checkHead($sformatf("drain%0d", k), 1'b1, drain_order[k]);
      applyStimulus(4'b0000, 1'b1);
    end
    checkOutput("drain_level", 64'(fifo_level), 64'd0);
    checkOutput("drain_valid", 64'(out_if.out_valid), 64'd0);

    // Build 3 records with channel 0's ack in flight, then apply reset.
    applyStimulus(4'b1111, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b1111, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b1111, 1'b0);
    checkOutput("pre_rst_level", 64'(fifo_level), 64'd3);
    checkOutput("pre_rst_rd", 64'(reset_decoder), 64'b0001);
    reset = 1'b1;
    applyStimulus(4'b1111, 1'b0);
    checkOutput("mid_rst_level", 64'(fifo_level), 64'd0);
    checkOutput("mid_rst_rd", 64'(reset_decoder), 64'd0);
    checkOutput("mid_rst_ts", 64'(system_timestamp), 64'd0);
    checkHead("mid_rst_head", 1'b0, 4'd0);
`ifdef RECV_STALL_COUNT_EN
    checkOutput("mid_rst_stall", 64'(stall_count), 64'd0);
`endif

    // After release, rr_ptr is back at 0 and pending is clear.
    reset = 1'b0;
    applyStimulus(4'b1111, 1'b0);
    checkOutput("post_rst_ts", 64'(system_timestamp), 64'd1);
    checkOutput("post_rst_rd", 64'(reset_decoder), 64'b0001);
    checkHead("post_rst_head", 1'b1, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
